// File: rtl/ui_press_classifier.sv
// Turns the debounced active-low button level into short, long,
// repeat and release pulses plus a held level.
module ui_press_classifier #(
  parameter int LONG_PRESS_CYCLES = 25_000_000,
  parameter int REPEAT_CYCLES     = 5_000_000,
  parameter bit REPEAT_EN         = 1'b1
) (
  input  logic clock_50Mhz,
  input  logic reset_n,
  input  logic button_n,
  output logic short_press,
  output logic long_press,
  output logic repeat_press,
  output logic released,
  output logic held
);

  localparam int MAX_CYC =
    (LONG_PRESS_CYCLES > REPEAT_CYCLES) ?
    LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LONG_C =
    CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] REP_C =
    CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_RELEASE,
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  state_t state;
  state_t stateNext;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;

  logic shortNext;
  logic longNext;
  logic repeatNext;
  logic releasedNext;
  logic heldNext;

  always_ff @(posedge clock_50Mhz) begin
    if (!reset_n) begin
      state        <= WAIT_RELEASE;
      count        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
      released     <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= stateNext;
      count        <= countNext;
      short_press  <= shortNext;
      long_press   <= longNext;
      repeat_press <= repeatNext;
      released     <= releasedNext;
      held         <= heldNext;
    end
  end

  always_comb begin
    stateNext    = state;
    countNext    = count;
    shortNext    = 1'b0;
    longNext     = 1'b0;
    repeatNext   = 1'b0;
    releasedNext = 1'b0;

    case (state)
      WAIT_RELEASE: begin
        if (button_n) begin
          stateNext = IDLE;
        end
      end
      IDLE: begin
        if (!button_n) begin
          stateNext = PRESSED;
          countNext = ONE_C;
        end
      end
      PRESSED: begin
        // A release on the threshold edge still counts as short.
        if (button_n) begin
          stateNext    = IDLE;
          shortNext    = 1'b1;
          releasedNext = 1'b1;
        end else if (count == LONG_C) begin
          stateNext = LONG_HELD;
          longNext  = 1'b1;
          countNext = ONE_C;
        end else begin
          countNext = count + ONE_C;
        end
      end
      LONG_HELD: begin
        if (button_n) begin
          stateNext    = IDLE;
          releasedNext = 1'b1;
        end else if (REPEAT_EN && count == REP_C) begin
          repeatNext = 1'b1;
          countNext  = ONE_C;
        end else if (count != REP_C) begin
          countNext = count + ONE_C;
        end
      end
      default: begin
        stateNext = WAIT_RELEASE;
        countNext = '0;
      end
    endcase

    heldNext = (stateNext == PRESSED) ||
               (stateNext == LONG_HELD);
  end

endmodule

// File: tb/tb_ui_press_classifier.sv
// Scoreboard bench: two classifiers, repeat enabled and disabled,
// with per-cycle expected pulse vectors queued at drive time.
module tb_ui_press_classifier;

  localparam int L = 8;
  localparam int R = 4;

  logic clock_50Mhz = 1'b0;
  logic reset_n     = 1'b0;
  logic buttonA     = 1'b0;
  logic buttonB     = 1'b1;

  logic shortA, longA, repA, relA, heldA;
  logic shortB, longB, repB, relB, heldB;

  typedef struct packed {
    logic [7:0] id;
    logic [4:0] a;
    logic [4:0] b;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int caseId   = 0;

  always #5 clock_50Mhz = ~clock_50Mhz;

  ui_press_classifier #(
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES(R),
    .REPEAT_EN(1'b1)
  ) dutA (
    .clock_50Mhz (clock_50Mhz),
    .reset_n     (reset_n),
    .button_n    (buttonA),
    .short_press (shortA),
    .long_press  (longA),
    .repeat_press(repA),
    .released    (relA),
    .held        (heldA)
  );

  ui_press_classifier #(
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES(R),
    .REPEAT_EN(1'b0)
  ) dutB (
    .clock_50Mhz (clock_50Mhz),
    .reset_n     (reset_n),
    .button_n    (buttonB),
    .short_press (shortB),
    .long_press  (longB),
    .repeat_press(repB),
    .released    (relB),
    .held        (heldB)
  );

  task automatic checkEq(
    input string      tag,
    input logic [4:0] got,
    input logic [4:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (s,l,r,rel,held)",
               tag, got, exp);
    end
  endtask

  always @(posedge clock_50Mhz) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkEq($sformatf("t%0d.A@%0t", e.id, $time),
              {shortA, longA, repA, relA, heldA}, e.a);
      checkEq($sformatf("t%0d.B@%0t", e.id, $time),
              {shortB, longB, repB, relB, heldB}, e.b);
    end
  end

  // Vector for offset i of an n-sample press released at offset n.
  function automatic logic [4:0] pressExp(
    input int i,
    input int n,
    input bit rep
  );
    logic s, lg, r, rel, h;
    h   = (i < n);
    rel = (i == n);
    s   = (i == n) && (n <= L);
    lg  = (i < n) && (i == L);
    r   = rep && (i < n) && (i > L) && (((i - L) % R) == 0);
    return {s, lg, r, rel, h};
  endfunction

  task automatic drive(
    input logic       btnA,
    input logic       btnB,
    input logic       rst,
    input logic [4:0] expA,
    input logic [4:0] expB
  );
    exp_t e;
    @(negedge clock_50Mhz);
    buttonA = btnA;
    buttonB = btnB;
    reset_n = rst;
    e.id = 8'(caseId);
    e.a  = expA;
    e.b  = expB;
    sb.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b1, 1'b1, 1'b1, '0, '0);
  endtask

  task automatic pressA(input int n);
    for (int i = 0; i <= n; i++)
      drive(i == n, 1'b1, 1'b1, pressExp(i, n, 1'b1), '0);
    idle(2);
  endtask

  task automatic pressB(input int n);
    for (int i = 0; i <= n; i++)
      drive(1'b1, i == n, 1'b1, '0, pressExp(i, n, 1'b0));
    idle(2);
  endtask

  initial begin
    // 1: button held through reset is ignored until released
    caseId = 1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b1, '0, '0);
    idle(2);
    pressA(3);

    // 2: plain short press
    caseId = 2;
    pressA(3);
    pressA(1);

    // 3: threshold edges of the long press
    caseId = 3;
    pressA(L);
    pressA(L + 1);

    // 4: repeats while held, and release on a repeat edge
    caseId = 4;
    pressA(21);
    pressA(L + R);

    // 5: reset mid-press aborts without pulses
    caseId = 5;
    for (int i = 0; i < 10; i++)
      drive(1'b0, 1'b1, 1'b1, pressExp(i, 100, 1'b1), '0);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, '0, '0);
    idle(2);
    pressA(2);

    // 6: repeat disabled, long hold
    caseId = 6;
    pressB(40);
    pressB(L - 1);

    @(negedge clock_50Mhz);
    @(negedge clock_50Mhz);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d need=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
